// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg: shared types and constants for the UART receive front end.
// Provides the receiver state encoding and the frame data width.
// Imported by the interface and the receiver core.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    BREAK,
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_core_if.sv
`timescale 1ns/1ps
// uart_rx_core_if: received-byte bus from the UART core to the downstream FIFO stage.
// Ports: out (last good byte), valid (one-cycle new-byte pulse),
//        framing_error (one-cycle bad-stop pulse). No ready: the sink always accepts.
interface uart_rx_core_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] out;
  logic                 valid;
  logic                 framing_error;

  modport master (output out, output valid, output framing_error);
  modport slave  (input  out, input  valid, input  framing_error);

endinterface

// File: rtl/sync_ff.sv
`timescale 1ns/1ps
// sync_ff: generic single-bit synchronizer chain of STAGES flops.
// Ports: clk, rst_n (async active-low, loads INIT), d (async input), q (synced output).
// Latency is STAGES clock cycles; no backpressure.
module sync_ff #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{INIT}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// uart_rx_core: 8N1 UART receiver; start detect, mid-bit sampling, stop-bit check.
// Ports: clk, rst_n (async active-low), in (raw serial line, idle high),
//        rx (master side of uart_rx_core_if: out / valid / framing_error).
// Pulses fire about 9.5 bit times + SYNC_STAGES cycles after the start edge;
// the sink has no backpressure, so each pulse is emitted exactly once.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in,
  uart_rx_core_if.master  rx
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic                 rx_s;
  uart_rx_state_t       state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shreg;

  sync_ff #(
    .STAGES (SYNC_STAGES),
    .INIT   (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= BREAK;
      cnt              <= '0;
      idx              <= '0;
      shreg            <= '0;
      rx.out           <= '0;
      rx.valid         <= 1'b0;
      rx.framing_error <= 1'b0;
    end else begin
      rx.valid         <= 1'b0;
      rx.framing_error <= 1'b0;
      cnt              <= cnt + 1'b1;

      case (state)
        // Wait for a high line so a frame cut by reset or a held-low
        // line is never decoded from its middle.
        BREAK: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end

        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end

        // Re-check the start bit at its centre; a high line here was a glitch.
        START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end
        end

        // Counting a full bit from the start-bit centre lands on each data-bit centre.
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            idx   <= idx + 1'b1;
            if (idx == IDX_LAST) state <= STOP;
          end
        end

        // Leaving at the stop-bit centre gives half a bit of slack for a
        // start bit that follows with no idle gap.
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx.out   <= shreg;
              rx.valid <= 1'b1;
              state    <= IDLE;
            end else begin
              rx.framing_error <= 1'b1;
              state            <= BREAK;
            end
          end
        end

        default: begin
          cnt   <= '0;
          state <= BREAK;
        end
      endcase
    end
  end

endmodule
